// File: rtl/hazard_scoreboard.sv
// Interlock and forwarding controller: a shift-register scoreboard of in-flight register
// writes past ID drives the ID stall/bubble, registered EX forward selects and a stall counter.
module hazard_scoreboard #(
  parameter int REG_ADDR_LEN = 5,
  parameter int DEPTH        = 3,
  parameter int ALU_LAT      = 1,
  parameter int LOAD_LAT     = 2,
  parameter int CNT_W        = 16,
  localparam int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_rs,
  input  logic [REG_ADDR_LEN-1:0] id_rt,
  input  logic                    id_rs_used,
  input  logic                    id_rt_used,
  input  logic                    id_wr_en,
  input  logic [REG_ADDR_LEN-1:0] id_wr_addr,
  input  logic                    id_is_load,
  input  logic                    flush,
  output logic                    stall,
  output logic                    bubble,
  output logic [SEL_W-1:0]        fwd_a_sel,
  output logic [SEL_W-1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]        stall_cnt
);

  // Entry k is the instruction that left ID k cycles ago; ld_q selects LOAD_LAT vs ALU_LAT.
  logic                    v_q     [1:DEPTH];
  logic [REG_ADDR_LEN-1:0] waddr_q [1:DEPTH];
  logic                    ld_q    [1:DEPTH];

  logic [SEL_W-1:0] sel_a_s, sel_b_s;
  logic [SEL_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic             haz_a_s, haz_b_s, stall_s, bubble_s, new_v_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A producer at distance k is not yet forwardable while k < lat - ALU_LAT + 1.
  function automatic logic is_hazard(input int k, input logic ld);
    int lat;
    lat = ld ? LOAD_LAT : ALU_LAT;
    return (k < (lat - ALU_LAT + 1));
  endfunction

  // Youngest-match search: scan oldest to youngest so the smallest k overwrites.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    haz_a_s = 1'b0;
    haz_b_s = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_rs_used && v_q[k] && (waddr_q[k] == id_rs) && (id_rs != '0)) begin
        sel_a_s = SEL_W'(k);
        haz_a_s = is_hazard(k, ld_q[k]);
      end else begin
        sel_a_s = sel_a_s;
      end
      if (id_rt_used && v_q[k] && (waddr_q[k] == id_rt) && (id_rt != '0)) begin
        sel_b_s = SEL_W'(k);
        haz_b_s = is_hazard(k, ld_q[k]);
      end else begin
        sel_b_s = sel_b_s;
      end
    end
  end

  // Stall/bubble decision, next forward selects, new entry 1 and saturating counter.
  always_comb begin
    stall_s  = id_valid && (haz_a_s || haz_b_s) && !flush;
    bubble_s = stall_s || flush;
    new_v_s  = id_valid && id_wr_en && (id_wr_addr != '0) && !bubble_s;
    fwd_a_d  = bubble_s ? '0 : sel_a_s;
    fwd_b_d  = bubble_s ? '0 : sel_b_s;
    cnt_d    = cnt_q;
    if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Scoreboard shift, forward-select and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_q[k]     <= 1'b0;
        waddr_q[k] <= '0;
        ld_q[k]    <= 1'b0;
      end
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        v_q[k]     <= v_q[k-1];
        waddr_q[k] <= waddr_q[k-1];
        ld_q[k]    <= ld_q[k-1];
      end
      v_q[1]     <= new_v_s;
      waddr_q[1] <= id_wr_addr;
      ld_q[1]    <= id_is_load;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      cnt_q      <= cnt_d;
    end
  end

  assign stall     = stall_s;
  assign bubble    = bubble_s;
  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default configuration plus a deep-pipeline,
// narrow-counter configuration (DEPTH=5, LOAD_LAT=4, CNT_W=2).
module tb_hazard_scoreboard;

  logic clk, rst;
  int   total, bad;

  logic       valid, rs_used, rt_used, wr_en, is_load, flush;
  logic [4:0] rs, rt, waddr;
  logic       stall, bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] cnt;

  logic       b_valid, b_rs_used, b_rt_used, b_wr_en, b_is_load, b_flush;
  logic [4:0] b_rs, b_rt, b_waddr;
  logic       b_stall, b_bubble;
  logic [2:0] b_fwd_a, b_fwd_b;
  logic [1:0] b_cnt;

  hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .id_valid(valid), .id_rs(rs), .id_rt(rt),
    .id_rs_used(rs_used), .id_rt_used(rt_used), .id_wr_en(wr_en), .id_wr_addr(waddr),
    .id_is_load(is_load), .flush(flush), .stall(stall), .bubble(bubble),
    .fwd_a_sel(fwd_a), .fwd_b_sel(fwd_b), .stall_cnt(cnt)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_LAT(4), .CNT_W(2)) u_deep (
    .clk(clk), .rst(rst), .id_valid(b_valid), .id_rs(b_rs), .id_rt(b_rt),
    .id_rs_used(b_rs_used), .id_rt_used(b_rt_used), .id_wr_en(b_wr_en), .id_wr_addr(b_waddr),
    .id_is_load(b_is_load), .flush(b_flush), .stall(b_stall), .bubble(b_bubble),
    .fwd_a_sel(b_fwd_a), .fwd_b_sel(b_fwd_b), .stall_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] s, input logic su,
                       input logic [4:0] t, input logic tu, input logic we,
                       input logic [4:0] wa, input logic ld, input logic fl);
    valid = v; rs = s; rs_used = su; rt = t; rt_used = tu;
    wr_en = we; waddr = wa; is_load = ld; flush = fl;
  endtask

  task automatic set_b(input logic v, input logic [4:0] s, input logic su,
                       input logic [4:0] t, input logic tu, input logic we,
                       input logic [4:0] wa, input logic ld, input logic fl);
    b_valid = v; b_rs = s; b_rs_used = su; b_rt = t; b_rt_used = tu;
    b_wr_en = we; b_waddr = wa; b_is_load = ld; b_flush = fl;
  endtask

  task automatic do_reset();
    set_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
    total++; if (bubble !== 1'b0) begin bad++; $display("FAIL reset_bubble: got %0b want 0", bubble); end
    total++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin bad++; $display("FAIL reset_fwd: got a=%0d b=%0d want 0 0", fwd_a, fwd_b); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    total++; if (b_cnt !== 2'd0 || b_fwd_a !== 3'd0) begin bad++; $display("FAIL reset_deep: got cnt=%0d a=%0d want 0 0", b_cnt, b_fwd_a); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    set_a(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);  // add r3,r1,r2
    tick();
    set_a(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);  // sub r4,r3,r5
    #1;
    total++; if (stall !== 1'b0 || bubble !== 1'b0) begin bad++; $display("FAIL alu_nostall: got stall=%0b bubble=%0b want 0 0", stall, bubble); end
    tick();
    total++; if (fwd_a !== 2'd1) begin bad++; $display("FAIL alu_fwd_a: got %0d want 1", fwd_a); end
    total++; if (fwd_b !== 2'd0) begin bad++; $display("FAIL alu_fwd_b: got %0d want 0", fwd_b); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_a(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);  // lw r3,0(r1)
    tick();
    set_a(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);  // add r4,r3,r3
    #1;
    total++; if (stall !== 1'b1 || bubble !== 1'b1) begin bad++; $display("FAIL lu_stall: got stall=%0b bubble=%0b want 1 1", stall, bubble); end
    tick();
    total++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin bad++; $display("FAIL lu_bubble_fwd: got a=%0d b=%0d want 0 0", fwd_a, fwd_b); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_resolve: got %0b want 0", stall); end
    tick();
    total++; if (fwd_a !== 2'd2 || fwd_b !== 2'd2) begin bad++; $display("FAIL lu_fwd: got a=%0d b=%0d want 2 2", fwd_a, fwd_b); end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_flush_hazard();
    do_reset();
    set_a(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);  // lw r3
    tick();
    set_a(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1);  // add r4,r3,r1 flushed
    #1;
    total++; if (stall !== 1'b0 || bubble !== 1'b1) begin bad++; $display("FAIL fl_out: got stall=%0b bubble=%0b want 0 1", stall, bubble); end
    tick();
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL fl_cnt: got %0d want 0", cnt); end
    set_a(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);  // reads r4 (squashed) and r3
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_after_stall: got %0b want 0", stall); end
    tick();
    total++; if (fwd_a !== 2'd0 || fwd_b !== 2'd2) begin bad++; $display("FAIL fl_noentry: got a=%0d b=%0d want 0 2", fwd_a, fwd_b); end
  endtask

  task automatic test_r0_youngest();
    do_reset();
    set_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);  // lw r0
    tick();
    set_a(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);  // add r0,r0,r0
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall: got %0b want 0", stall); end
    tick();
    total++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin bad++; $display("FAIL r0_fwd: got a=%0d b=%0d want 0 0", fwd_a, fwd_b); end
    set_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);  // lw r7 (older)
    tick();
    set_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);  // addi r7 (younger)
    tick();
    set_a(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);  // read r7 on rs only
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL yng_stall: got %0b want 0", stall); end
    tick();
    total++; if (fwd_a !== 2'd1) begin bad++; $display("FAIL yng_fwd_a: got %0d want 1", fwd_a); end
    total++; if (fwd_b !== 2'd0) begin bad++; $display("FAIL unused_fwd_b: got %0d want 0", fwd_b); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_a(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);  // lw r9
    tick();
    set_a(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);  // use r9
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_pre: got %0b want 1", stall); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || bubble !== 1'b0) begin bad++; $display("FAIL mid_stall: got stall=%0b bubble=%0b want 0 0", stall, bubble); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", cnt); end
  endtask

  task automatic test_deep();
    do_reset();
    set_b(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);  // lw r2
    tick();
    set_b(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0);  // use r2
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL deep_stall%0d: got %0b want 1", i, b_stall); end
      tick();
    end
    total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL deep_resolve: got %0b want 0", b_stall); end
    total++; if (b_cnt !== 2'd3) begin bad++; $display("FAIL deep_cnt3: got %0d want 3", b_cnt); end
    tick();
    total++; if (b_fwd_a !== 3'd4) begin bad++; $display("FAIL deep_fwd: got %0d want 4", b_fwd_a); end
    set_b(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);  // lw r6
    tick();
    set_b(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);  // independent
    tick();
    set_b(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);  // use r6 at distance 2
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL deep2_stall%0d: got %0b want 1", i, b_stall); end
      tick();
    end
    total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL deep2_resolve: got %0b want 0", b_stall); end
    total++; if (b_cnt !== 2'd3) begin bad++; $display("FAIL deep_sat: got %0d want 3", b_cnt); end
    tick();
    total++; if (b_fwd_b !== 3'd4) begin bad++; $display("FAIL deep2_fwd: got %0d want 4", b_fwd_b); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_flush_hazard();
    test_r0_youngest();
    test_reset_mid_stall();
    test_deep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
